// File: rtl/risc_v_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 sizes, FSM states, lane masks.
package risc_v_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;

  // Byte-lane mask for an access of 1, 2, 4 or 8 bytes (funct3[1:0]).
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data shift / access check,
// and load lane extraction with sign or zero extension.
module lsu_align
  import risc_v_mem_pkg::*;
#(
  parameter  int unsigned REG_WIDTH = 32,
  localparam int unsigned BE_W      = REG_WIDTH / 8,
  localparam int unsigned OFF_W     = $clog2(BE_W)
) (
  input  logic [2:0]           st_funct3_i,
  input  logic [OFF_W-1:0]     st_off_i,
  input  logic [REG_WIDTH-1:0] st_data_i,
  output logic [BE_W-1:0]      st_be_o,
  output logic [REG_WIDTH-1:0] st_wdata_o,
  output logic                 st_err_o,
  input  logic [2:0]           ld_funct3_i,
  input  logic [OFF_W-1:0]     ld_off_i,
  input  logic [REG_WIDTH-1:0] ld_rdata_i,
  output logic [REG_WIDTH-1:0] ld_data_o
);

  localparam bit IS64 = (REG_WIDTH == 64);

  logic                 legal;
  logic [OFF_W-1:0]     align_mask;
  logic [7:0]           lane_mask;
  logic [REG_WIDTH-1:0] ld_shift;

  // Request side: legality, alignment, lane placement.
  always_comb begin
    legal = 1'b0;
    case (st_funct3_i)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
      F3_D, F3_WU:                    legal = IS64;
      default:                        legal = 1'b0;
    endcase
    lane_mask  = size_mask(st_funct3_i[1:0]);
    align_mask = OFF_W'((8'd1 << st_funct3_i[1:0]) - 8'd1);
    st_err_o   = !legal || ((st_off_i & align_mask) != '0);
    st_be_o    = BE_W'(lane_mask) << st_off_i;
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
  end

  // Response side: bring the addressed lane down to bit 0 and extend.
  always_comb begin
    ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_data_o = REG_WIDTH'($signed(ld_shift[7:0]));
      F3_BU:   ld_data_o = REG_WIDTH'(ld_shift[7:0]);
      F3_H:    ld_data_o = REG_WIDTH'($signed(ld_shift[15:0]));
      F3_HU:   ld_data_o = REG_WIDTH'(ld_shift[15:0]);
      F3_W:    ld_data_o = REG_WIDTH'($signed(ld_shift[31:0]));
      F3_WU:   ld_data_o = REG_WIDTH'(ld_shift[31:0]);
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: load/store unit on a req/ack data memory port with a
// registered MEM/WB output and upstream stall while an access is in flight.
module stage_mem_lsu
  import risc_v_mem_pkg::*;
#(
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned DMEM_ADDR_WIDTH = 10,
  parameter int unsigned RD_WIDTH        = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_valid,
  input  logic                       ex_mem_read,
  input  logic                       ex_mem_write,
  input  logic [2:0]                 ex_funct3,
  input  logic [REG_WIDTH-1:0]       ex_alu_out,
  input  logic [REG_WIDTH-1:0]       ex_dataB,
  input  logic [RD_WIDTH-1:0]        ex_rd,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH/8-1:0]     dmem_be,
  output logic [REG_WIDTH-1:0]       dmem_wdata,
  input  logic [REG_WIDTH-1:0]       dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       mem_stall,
  output logic                       wb_valid,
  output logic                       wb_we,
  output logic [RD_WIDTH-1:0]        wb_rd,
  output logic [REG_WIDTH-1:0]       wb_data,
  output logic                       access_err
);

  localparam int unsigned BE_W  = REG_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  lsu_state_e                 state_q;
  logic                       req_q, we_q, is_store_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [BE_W-1:0]            be_q;
  logic [REG_WIDTH-1:0]       wdata_q;
  logic [2:0]                 ld_funct3_q;
  logic [OFF_W-1:0]           ld_off_q;
  logic [RD_WIDTH-1:0]        rd_q;
  logic                       wb_valid_q, wb_we_q, err_q;
  logic [RD_WIDTH-1:0]        wb_rd_q;
  logic [REG_WIDTH-1:0]       wb_data_q;

  logic [BE_W-1:0]      st_be;
  logic [REG_WIDTH-1:0] st_wdata;
  logic                 st_err;
  logic [REG_WIDTH-1:0] ld_data;
  logic                 is_mem;

  assign is_mem = ex_mem_read || ex_mem_write;

  lsu_align #(.REG_WIDTH(REG_WIDTH)) u_align (
    .st_funct3_i (ex_funct3),
    .st_off_i    (ex_alu_out[OFF_W-1:0]),
    .st_data_i   (ex_dataB),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .st_err_o    (st_err),
    .ld_funct3_i (ld_funct3_q),
    .ld_off_i    (ld_off_q),
    .ld_rdata_i  (dmem_rdata),
    .ld_data_o   (ld_data)
  );

  // Access FSM plus memory-port and MEM/WB registers; WB strobes pulse for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LSU_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      is_store_q  <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      err_q       <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (ex_valid) begin
            wb_rd_q <= ex_rd;
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b1;
              wb_data_q  <= ex_alu_out;
            end else if (st_err) begin
              wb_valid_q <= 1'b1;
              err_q      <= 1'b1;
              wb_data_q  <= '0;
            end else begin
              state_q     <= LSU_BUSY;
              req_q       <= 1'b1;
              we_q        <= ex_mem_write;
              is_store_q  <= ex_mem_write;
              addr_q      <= ex_alu_out[DMEM_ADDR_WIDTH+OFF_W-1:OFF_W];
              be_q        <= st_be;
              wdata_q     <= ex_mem_write ? st_wdata : '0;
              ld_funct3_q <= ex_funct3;
              ld_off_q    <= ex_alu_out[OFF_W-1:0];
              rd_q        <= ex_rd;
            end
          end
        end
        LSU_BUSY: begin
          if (dmem_ack) begin
            state_q    <= LSU_IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            if (!is_store_q) begin
              wb_we_q   <= 1'b1;
              wb_data_q <= ld_data;
            end
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign mem_stall  = (state_q == LSU_BUSY);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign access_err = err_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed bench for stage_mem_lsu: a 32-bit instance for the main flows and a
// 64-bit instance for doubleword / unsigned-word loads.
module tb_stage_mem_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_dataB, dmem_rdata, dmem_wdata, wb_data;
  logic [4:0]  ex_rd, wb_rd;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, wb_valid, wb_we, access_err;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;

  // 64-bit instance
  logic        q_ex_valid, q_ex_mem_read, q_ex_mem_write;
  logic [2:0]  q_ex_funct3;
  logic [63:0] q_ex_alu_out, q_ex_dataB, q_dmem_rdata, q_dmem_wdata, q_wb_data;
  logic [4:0]  q_ex_rd, q_wb_rd;
  logic        q_dmem_req, q_dmem_we, q_dmem_ack, q_mem_stall, q_wb_valid, q_wb_we, q_access_err;
  logic [9:0]  q_dmem_addr;
  logic [7:0]  q_dmem_be;

  int n_assert = 0;
  int n_fail   = 0;

  stage_mem_lsu #(.REG_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out),
    .ex_dataB(ex_dataB), .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .access_err(access_err)
  );

  stage_mem_lsu #(.REG_WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .ex_valid(q_ex_valid), .ex_mem_read(q_ex_mem_read),
    .ex_mem_write(q_ex_mem_write), .ex_funct3(q_ex_funct3), .ex_alu_out(q_ex_alu_out),
    .ex_dataB(q_ex_dataB), .ex_rd(q_ex_rd), .dmem_req(q_dmem_req), .dmem_we(q_dmem_we),
    .dmem_addr(q_dmem_addr), .dmem_be(q_dmem_be), .dmem_wdata(q_dmem_wdata),
    .dmem_rdata(q_dmem_rdata), .dmem_ack(q_dmem_ack), .mem_stall(q_mem_stall),
    .wb_valid(q_wb_valid), .wb_we(q_wb_we), .wb_rd(q_wb_rd), .wb_data(q_wb_data),
    .access_err(q_access_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_alu_out = addr; ex_dataB = data; ex_rd = dst;
  endtask

  task automatic drop();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drop(); ex_funct3 = '0; ex_alu_out = '0; ex_dataB = '0; ex_rd = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    q_ex_valid = 1'b0; q_ex_mem_read = 1'b0; q_ex_mem_write = 1'b0; q_ex_funct3 = '0;
    q_ex_alu_out = '0; q_ex_dataB = '0; q_ex_rd = '0; q_dmem_rdata = '0; q_dmem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_be", 64'(dmem_be), 64'd0);

    // ALU passthrough
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
    step();
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_wb_we", 64'(wb_we), 64'd1);
    chk("alu_wb_data", 64'(wb_data), 64'h1234);
    chk("alu_wb_rd", 64'(wb_rd), 64'd5);
    chk("alu_stall", 64'(mem_stall), 64'd0);
    chk("alu_req", 64'(dmem_req), 64'd0);
    drop();
    step();
    chk("alu_pulse", 64'(wb_valid), 64'd0);
    chk("alu_hold", 64'(wb_data), 64'h1234);

    // SB at 0x103, ack three cycles after req
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0);
    step();
    drop();
    chk("sb_req", 64'(dmem_req), 64'd1);
    chk("sb_we", 64'(dmem_we), 64'd1);
    chk("sb_addr", 64'(dmem_addr), 64'h40);
    chk("sb_be", 64'(dmem_be), 64'b1000);
    chk("sb_wdata", 64'(dmem_wdata), 64'hAB000000);
    chk("sb_stall1", 64'(mem_stall), 64'd1);
    step();
    chk("sb_stall2", 64'(mem_stall), 64'd1);
    chk("sb_hold_addr", 64'(dmem_addr), 64'h40);
    step();
    chk("sb_stall3", 64'(mem_stall), 64'd1);
    chk("sb_no_wb", 64'(wb_valid), 64'd0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sb_wb_valid", 64'(wb_valid), 64'd1);
    chk("sb_wb_we", 64'(wb_we), 64'd0);
    chk("sb_req_drop", 64'(dmem_req), 64'd0);
    chk("sb_stall_end", 64'(mem_stall), 64'd0);

    // LB at 0x002 with same-cycle ack
    issue(1'b1, 1'b0, 3'b000, 32'h002, 32'h0, 5'd7);
    step();
    drop();
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_be", 64'(dmem_be), 64'b0100);
    dmem_rdata = 32'h00800000; dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("lb_wb_valid", 64'(wb_valid), 64'd1);
    chk("lb_wb_we", 64'(wb_we), 64'd1);
    chk("lb_wb_data", 64'(wb_data), 64'hFFFFFF80);
    chk("lb_wb_rd", 64'(wb_rd), 64'd7);

    // LBU at 0x002
    issue(1'b1, 1'b0, 3'b100, 32'h002, 32'h0, 5'd8);
    step();
    drop();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("lbu_wb_data", 64'(wb_data), 64'h00000080);
    chk("lbu_wb_valid", 64'(wb_valid), 64'd1);

    // Misaligned LH, then back-to-back LW accepted next cycle
    issue(1'b1, 1'b0, 3'b001, 32'h001, 32'h0, 5'd3);
    step();
    chk("lh_err", 64'(access_err), 64'd1);
    chk("lh_no_req", 64'(dmem_req), 64'd0);
    chk("lh_wb_valid", 64'(wb_valid), 64'd1);
    chk("lh_wb_we", 64'(wb_we), 64'd0);
    chk("lh_wb_data", 64'(wb_data), 64'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h004, 32'h0, 5'd9);
    step();
    drop();
    chk("lw_req", 64'(dmem_req), 64'd1);
    chk("lw_addr", 64'(dmem_addr), 64'd1);
    chk("lw_be", 64'(dmem_be), 64'hF);
    chk("lw_err_pulse", 64'(access_err), 64'd0);
    dmem_rdata = 32'hDEADBEEF; dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("lw_wb_data", 64'(wb_data), 64'hDEADBEEF);
    chk("lw_wb_rd", 64'(wb_rd), 64'd9);

    // Doubleword and funct3=111 are illegal on a 32-bit datapath
    issue(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 5'd1);
    step();
    chk("ld32_err", 64'(access_err), 64'd1);
    chk("ld32_no_req", 64'(dmem_req), 64'd0);
    issue(1'b0, 1'b1, 3'b111, 32'h000, 32'h0, 5'd1);
    step();
    drop();
    chk("f7_err", 64'(access_err), 64'd1);

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("idle_ack_wb", 64'(wb_valid), 64'd0);
    chk("idle_ack_stall", 64'(mem_stall), 64'd0);

    // SH at 0x102: upper half lane
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    step();
    drop();
    chk("sh_be", 64'(dmem_be), 64'b1100);
    chk("sh_wdata", 64'(dmem_wdata), 64'hABCD0000);
    chk("sh_addr", 64'(dmem_addr), 64'h40);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sh_wb_valid", 64'(wb_valid), 64'd1);

    // Reset while busy drops the op; a later ack is ignored
    issue(1'b1, 1'b0, 3'b010, 32'h008, 32'h0, 5'd4);
    step();
    drop();
    chk("rb_req", 64'(dmem_req), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rb_req_drop", 64'(dmem_req), 64'd0);
    chk("rb_stall", 64'(mem_stall), 64'd0);
    chk("rb_no_wb", 64'(wb_valid), 64'd0);
    dmem_rdata = 32'h55555555; dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("rb_ack_wb", 64'(wb_valid), 64'd0);
    chk("rb_ack_stall", 64'(mem_stall), 64'd0);
    chk("rb_ack_data", 64'(wb_data), 64'd0);

    // 64-bit: LD at 0x8
    q_ex_valid = 1'b1; q_ex_mem_read = 1'b1; q_ex_funct3 = 3'b011;
    q_ex_alu_out = 64'h8; q_ex_rd = 5'd3;
    step();
    q_ex_valid = 1'b0;
    chk("ld64_be", 64'(q_dmem_be), 64'hFF);
    chk("ld64_addr", 64'(q_dmem_addr), 64'd1);
    q_dmem_rdata = 64'h0123456789ABCDEF; q_dmem_ack = 1'b1;
    step();
    q_dmem_ack = 1'b0;
    chk("ld64_data", q_wb_data, 64'h0123456789ABCDEF);

    // 64-bit: LWU then LW at 0x4, upper word 0x80000000
    q_ex_valid = 1'b1; q_ex_funct3 = 3'b110; q_ex_alu_out = 64'h4;
    step();
    q_ex_valid = 1'b0;
    chk("lwu64_be", 64'(q_dmem_be), 64'hF0);
    chk("lwu64_addr", 64'(q_dmem_addr), 64'd0);
    q_dmem_rdata = 64'h80000000_12345678; q_dmem_ack = 1'b1;
    step();
    q_dmem_ack = 1'b0;
    chk("lwu64_data", q_wb_data, 64'h0000000080000000);
    q_ex_valid = 1'b1; q_ex_funct3 = 3'b010;
    step();
    q_ex_valid = 1'b0;
    q_dmem_ack = 1'b1;
    step();
    q_dmem_ack = 1'b0;
    chk("lw64_data", q_wb_data, 64'hFFFFFFFF80000000);
    chk("lw64_wb_we", 64'(q_wb_we), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
